// File: rtl/hci_meas_scheduler.sv
// hci_meas_scheduler: stress, settle and measure sequencer for HCI ring-oscillator sensors sharing one counter
module hci_meas_scheduler #(
    parameter int NUM_SENSORS = 4,
    parameter int CNT_WIDTH = 32,
    parameter int WIN_WIDTH = 16,
    parameter int SETTLE_CYCLES = 8,
    localparam int IDW = NUM_SENSORS > 1 ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [31:0]            stress_cycles,
    input  logic [WIN_WIDTH-1:0]   window_cycles,
    input  logic [NUM_SENSORS-1:0] ro_pulse,
    output logic [NUM_SENSORS-1:0] stress_en,
    output logic [NUM_SENSORS-1:0] ro_en,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CNT_WIDTH-1:0]   result_data,
    output logic [IDW-1:0]         result_id,
    output logic                   result_sat,
    output logic                   busy,
    output logic                   done
);
    localparam int TW = WIN_WIDTH > $clog2(SETTLE_CYCLES) + 1 ? WIN_WIDTH : $clog2(SETTLE_CYCLES) + 1;
    typedef enum logic [2:0] {IDLE, STRESS, SETTLE, MEASURE, REPORT, FINISH} state_t;
    state_t state;
    logic [NUM_SENSORS-1:0] mask_q;
    logic [31:0] stress_cnt;
    logic [WIN_WIDTH-1:0] win_q, win_end;
    logic [TW-1:0] tmr;
    logic [IDW-1:0] sel;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic sat;
    logic [IDW:0] first, after;

    // {found, index} of the lowest set mask bit at or above 'from'
    function automatic logic [IDW:0] nxt_bit(input logic [NUM_SENSORS-1:0] m, input int from);
        nxt_bit = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--)
            if (m[i] && i >= from) nxt_bit = {1'b1, IDW'(i)};
    endfunction

    always_comb begin
        first = nxt_bit(state == IDLE ? sensor_mask : mask_q, 0);
        after = nxt_bit(mask_q, int'(sel) + 1);
        win_end = win_q == '0 ? '0 : win_q - WIN_WIDTH'(1);
        cnt_nxt = cnt + CNT_WIDTH'(ro_pulse[sel] && !(&cnt));
    end

    assign result_data = cnt;
    assign result_id = sel;
    assign result_sat = sat;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            mask_q <= '0;
            win_q <= '0;
            stress_cnt <= '0;
            tmr <= '0;
            sel <= '0;
            cnt <= '0;
            sat <= 1'b0;
            stress_en <= '0;
            ro_en <= '0;
            result_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            stress_cnt <= '0;
            tmr <= '0;
            sel <= '0;
            cnt <= '0;
            sat <= 1'b0;
            stress_en <= '0;
            ro_en <= '0;
            result_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mask_q <= sensor_mask;
                    win_q <= window_cycles;
                    stress_cnt <= stress_cycles;
                    busy <= 1'b1;
                    if (!first[IDW]) begin
                        state <= FINISH;
                        done <= 1'b1;
                    end else if (stress_cycles == 32'd0) begin
                        state <= SETTLE;
                        sel <= first[IDW-1:0];
                        ro_en <= NUM_SENSORS'(1) << first[IDW-1:0];
                    end else begin
                        state <= STRESS;
                        stress_en <= sensor_mask;
                    end
                end
                STRESS: begin
                    stress_cnt <= stress_cnt - 32'd1;
                    if (stress_cnt == 32'd1) begin
                        state <= SETTLE;
                        stress_en <= '0;
                        sel <= first[IDW-1:0];
                        ro_en <= NUM_SENSORS'(1) << first[IDW-1:0];
                    end
                end
                SETTLE: begin
                    cnt <= '0;
                    sat <= 1'b0;
                    tmr <= tmr + TW'(1);
                    if (tmr == TW'(SETTLE_CYCLES - 1)) begin
                        tmr <= '0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    cnt <= cnt_nxt;
                    sat <= sat | (&cnt_nxt);
                    tmr <= tmr + TW'(1);
                    if (tmr == TW'(win_end)) begin
                        tmr <= '0;
                        state <= REPORT;
                        ro_en <= '0;
                        result_valid <= 1'b1;
                    end
                end
                REPORT: if (result_ready) begin
                    result_valid <= 1'b0;
                    if (after[IDW]) begin
                        state <= SETTLE;
                        sel <= after[IDW-1:0];
                        ro_en <= NUM_SENSORS'(1) << after[IDW-1:0];
                    end else begin
                        state <= FINISH;
                        done <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hci_meas_scheduler.sv
// tb_hci_meas_scheduler: directed vector table plus stall, abort and reset sequences
module tb_hci_meas_scheduler;
    localparam int SETTLE = 8;
    logic ACLK = 1'b0, ARESET, start, abort, result_ready;
    logic [3:0] sensor_mask, ro_pulse;
    logic [31:0] stress_cycles;
    logic [15:0] window_cycles;
    logic [3:0] stress_en, ro_en, s_stress_en, s_ro_en;
    logic result_valid, result_sat, busy, done, s_valid, s_sat, s_busy, s_done;
    logic [31:0] result_data;
    logic [3:0] s_data;
    logic [1:0] result_id, s_id;
    logic [3:0][7:0] div;
    int cyc = 0, checks = 0, errors = 0;

    always #5 ACLK = ~ACLK;

    hci_meas_scheduler dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort), .sensor_mask(sensor_mask),
        .stress_cycles(stress_cycles), .window_cycles(window_cycles), .ro_pulse(ro_pulse),
        .stress_en(stress_en), .ro_en(ro_en), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_id(result_id), .result_sat(result_sat), .busy(busy), .done(done)
    );

    hci_meas_scheduler #(.CNT_WIDTH(4)) u_sat (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort), .sensor_mask(sensor_mask),
        .stress_cycles(stress_cycles), .window_cycles(window_cycles), .ro_pulse(ro_pulse),
        .stress_en(s_stress_en), .ro_en(s_ro_en), .result_valid(s_valid), .result_ready(result_ready),
        .result_data(s_data), .result_id(s_id), .result_sat(s_sat), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        logic [3:0] mask;
        int stress;
        int win;
        logic [3:0][7:0] div;
        logic [3:0][31:0] exp;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        cyc++;
        for (int i = 0; i < 4; i++) ro_pulse[i] = (div[i] != 0) && (cyc % int'(div[i]) == 0);
    endtask

    function automatic logic [63:0] all_out();
        return {result_data, busy, done, result_valid, result_sat, stress_en, ro_en, result_id,
                s_busy, s_done, s_valid, s_stress_en, s_ro_en};
    endfunction

    task automatic run(input string nm, input vec_t v, input logic ab);
        int busy_n = 0, st_n = 0, res_n = 0, done_n = 0, inv_n = 0, k = 0, w, n, e;
        logic fin = 1'b0;
        tick();
        sensor_mask = v.mask;
        stress_cycles = v.stress;
        window_cycles = v.win[15:0];
        div = v.div;
        start = 1'b1;
        abort = ab;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        w = v.win == 0 ? 1 : v.win;
        n = $countones(v.mask);
        for (int c = 0; c < 3000; c++) begin
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            busy_n++;
            if (stress_en != 0) st_n++;
            if (stress_en != 0 && stress_en != v.mask) inv_n++;
            if (stress_en != 0 && ro_en != 0) inv_n++;
            if ((ro_en & (ro_en - 4'd1)) != 0) inv_n++;
            if (done) done_n++;
            if (result_valid) begin
                while (k < 4 && !v.mask[k]) k++;
                e = k < 4 ? int'(v.exp[k]) : 0;
                chk({nm, "_id"}, result_id, k);
                chk({nm, "_data"}, result_data, e);
                chk({nm, "_sat"}, result_sat, 0);
                chk({nm, "_s_valid"}, s_valid, 1);
                chk({nm, "_s_data"}, s_data, e > 15 ? 15 : e);
                chk({nm, "_s_sat"}, s_sat, e >= 15);
                k++;
                res_n++;
            end
            tick();
        end
        chk({nm, "_finished"}, fin, 1);
        chk({nm, "_busy_cycles"}, busy_n, n == 0 ? 1 : v.stress + n * (SETTLE + w + 1) + 1);
        chk({nm, "_stress_cycles"}, st_n, n == 0 ? 0 : v.stress);
        chk({nm, "_results"}, res_n, n);
        chk({nm, "_done"}, done_n, 1);
        chk({nm, "_invariants"}, inv_n, 0);
    endtask

    initial begin
        int bad, seen;
        vec_t va;
        vecs[0] = '{4'b0101, 10, 20, {8'd0, 8'd4, 8'd0, 8'd1}, {32'd0, 32'd5, 32'd0, 32'd20}};
        vecs[1] = '{4'b0000, 7, 5, {8'd1, 8'd1, 8'd1, 8'd1}, {32'd0, 32'd0, 32'd0, 32'd0}};
        vecs[2] = '{4'b1000, 0, 0, {8'd1, 8'd0, 8'd0, 8'd0}, {32'd1, 32'd0, 32'd0, 32'd0}};
        vecs[3] = '{4'b0010, 3, 40, {8'd0, 8'd0, 8'd1, 8'd0}, {32'd0, 32'd0, 32'd40, 32'd0}};
        vecs[4] = '{4'b1111, 2, 8, {8'd8, 8'd4, 8'd2, 8'd1}, {32'd1, 32'd2, 32'd4, 32'd8}};
        vecs[5] = '{4'b0110, 1, 1, {8'd1, 8'd1, 8'd1, 8'd1}, {32'd0, 32'd1, 32'd1, 32'd0}};
        ARESET = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        result_ready = 1'b0;
        sensor_mask = '0;
        stress_cycles = '0;
        window_cycles = '0;
        div = '0;
        ro_pulse = '0;
        repeat (3) tick();
        chk("reset_outputs", all_out(), 0);
        ARESET = 1'b0;

        for (int i = 0; i < 6; i++) run($sformatf("v%0d", i), vecs[i], 1'b0);

        // ready held low in the first REPORT; a stray start must not disturb the sequence
        tick();
        sensor_mask = 4'b0011;
        stress_cycles = 0;
        window_cycles = 4;
        div = {8'd1, 8'd1, 8'd1, 8'd1};
        start = 1'b1;
        result_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && !result_valid; c++) tick();
        chk("stall_reach", result_valid, 1);
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            if (!(result_valid && result_id == 0 && result_data == 4 && ro_en == 0 && busy)) bad++;
            start = (j == 10);
            if (j == 10) sensor_mask = 4'b1000;
            tick();
        end
        chk("stall_stable", bad, 0);
        result_ready = 1'b1;
        tick();
        chk("stall_release_valid", result_valid, 0);
        chk("stall_release_ro_en", ro_en, 4'b0010);
        for (int c = 0; c < 100 && !result_valid; c++) tick();
        chk("stall_second_id", result_id, 1);
        chk("stall_second_data", result_data, 4);
        seen = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            if (done) seen++;
            tick();
        end
        chk("stall_done", seen, 1);

        // abort mid-MEASURE, then start together with abort in IDLE
        tick();
        sensor_mask = 4'b0001;
        stress_cycles = 0;
        window_cycles = 100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("abort_pre_ro_en", ro_en, 4'b0001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outputs", all_out(), 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy || result_valid) seen++;
            tick();
        end
        chk("abort_quiet", seen, 0);
        va = '{4'b0100, 3, 8, {8'd0, 8'd2, 8'd0, 8'd0}, {32'd0, 32'd4, 32'd0, 32'd0}};
        run("start_abort", va, 1'b1);

        // reset in the middle of STRESS
        tick();
        sensor_mask = 4'b1111;
        stress_cycles = 50;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("reset_pre_stress", stress_en, 4'b1111);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("reset_mid_stress", all_out(), 0);
        run("post_reset", vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
